// File: rtl/rfile_seq_ctrl.sv
// rfile_seq_ctrl: sequences three anchor exponent lookups and a solver run per start request.
// Define RFILE_TIMEOUT_EN to abort a stalled lookup after TMO_CYC cycles with err=1.
module rfile_seq_ctrl #(
    parameter int TMO_CYC = 15,
    parameter int EXP_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [19:0]      rssiA,
    input  logic [19:0]      rssiB,
    input  logic [19:0]      rssiC,
    output logic             exp_req,
    output logic [1:0]       exp_sel,
    output logic [EXP_W-1:0] exp_out,
    input  logic [15:0]      value_in,
    input  logic             value_vld,
    output logic [15:0]      valA,
    output logic [15:0]      valB,
    output logic [15:0]      valC,
    output logic             solve_start,
    input  logic             solve_done,
    output logic             busy,
    output logic             out_valid,
    output logic             err
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] REQ_A  = 4'd1;
    localparam logic [3:0] WAIT_A = 4'd2;
    localparam logic [3:0] REQ_B  = 4'd3;
    localparam logic [3:0] WAIT_B = 4'd4;
    localparam logic [3:0] REQ_C  = 4'd5;
    localparam logic [3:0] WAIT_C = 4'd6;
    localparam logic [3:0] SOLVE  = 4'd7;
    localparam logic [3:0] WAIT_S = 4'd8;
    localparam logic [3:0] DONE   = 4'd9;

    logic [3:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [EXP_W-1:0] out_q, out_d;
    logic [EXP_W-1:0] rb_q, rb_d, rc_q, rc_d;
    logic [15:0]      va_q, va_d, vb_q, vb_d, vc_q, vc_d;
    logic             waiting;
    logic             unused_bits;

    // Anchor A's exponent goes straight to exp_out on the start edge, so only B and C are held.
    assign unused_bits = ^{rssiA[19-EXP_W:0], rssiB[19-EXP_W:0], rssiC[19-EXP_W:0]};
    assign waiting     = state_q inside {WAIT_A, WAIT_B, WAIT_C};
    assign exp_req     = state_q inside {REQ_A, REQ_B, REQ_C};
    assign solve_start = state_q == SOLVE;
    assign busy        = state_q != IDLE;
    assign out_valid   = state_q == DONE;
    assign exp_sel     = sel_q;
    assign exp_out     = out_q;
    assign valA        = va_q;
    assign valB        = vb_q;
    assign valC        = vc_q;

`ifdef RFILE_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    assign err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        out_d   = out_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        va_d    = va_q;
        vb_d    = vb_q;
        vc_d    = vc_q;
`ifdef RFILE_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = REQ_A;
                rb_d    = rssiB[19 -: EXP_W];
                rc_d    = rssiC[19 -: EXP_W];
                sel_d   = 2'd0;
                out_d   = rssiA[19 -: EXP_W];
            end
            REQ_A:  state_d = WAIT_A;
            WAIT_A: if (value_vld) begin
                va_d    = value_in;
                state_d = REQ_B;
                sel_d   = 2'd1;
                out_d   = rb_q;
            end
            REQ_B:  state_d = WAIT_B;
            WAIT_B: if (value_vld) begin
                vb_d    = value_in;
                state_d = REQ_C;
                sel_d   = 2'd2;
                out_d   = rc_q;
            end
            REQ_C:  state_d = WAIT_C;
            WAIT_C: if (value_vld) begin
                vc_d    = value_in;
                state_d = SOLVE;
            end
            SOLVE:  state_d = WAIT_S;
            WAIT_S: state_d = solve_done ? DONE : WAIT_S;
            default: state_d = IDLE;
        endcase
`ifdef RFILE_TIMEOUT_EN
        if (exp_req) cnt_d = '0;
        else if (waiting && !value_vld) begin
            if (cnt_q == 8'(TMO_CYC - 1)) begin
                state_d = DONE;
                err_d   = 1'b1;
            end else cnt_d = cnt_q + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            out_q   <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            va_q    <= '0;
            vb_q    <= '0;
            vc_q    <= '0;
`ifdef RFILE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
            vc_q    <= vc_d;
`ifdef RFILE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_rfile_seq_ctrl.sv
// tb_rfile_seq_ctrl: directed checks of the localization sequencer.
module tb_rfile_seq_ctrl;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [19:0] rssiA = '0, rssiB = '0, rssiC = '0;
    logic        exp_req, solve_start, busy, out_valid, err;
    logic [1:0]  exp_sel;
    logic [11:0] exp_out;
    logic [15:0] value_in = '0, valA, valB, valC;
    logic        value_vld = 1'b0, solve_done = 1'b0;
    int          pass_n = 0, total_n = 0;

    rfile_seq_ctrl #(.TMO_CYC(15), .EXP_W(12)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rssiA(rssiA), .rssiB(rssiB), .rssiC(rssiC),
        .exp_req(exp_req), .exp_sel(exp_sel), .exp_out(exp_out),
        .value_in(value_in), .value_vld(value_vld),
        .valA(valA), .valB(valB), .valC(valC),
        .solve_start(solve_start), .solve_done(solve_done),
        .busy(busy), .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c);
        rssiA = a; rssiB = b; rssiC = c; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v);
        value_in = v; value_vld = 1'b1;
        tick;
        value_vld = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total_n++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_n++;
        total_n++; if (out_valid !== 1'b0 || err !== 1'b0) $display("FAIL rst_ov_err got %b%b want 00", out_valid, err); else pass_n++;
        total_n++; if (exp_req !== 1'b0 || solve_start !== 1'b0) $display("FAIL rst_pulses got %b%b want 00", exp_req, solve_start); else pass_n++;
        total_n++; if (exp_sel !== 2'd0 || exp_out !== 12'h0) $display("FAIL rst_exp got %h/%h want 0/000", exp_sel, exp_out); else pass_n++;
        total_n++; if ({valA, valB, valC} !== 48'h0) $display("FAIL rst_vals got %h want 0", {valA, valB, valC}); else pass_n++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_nominal;
        launch(20'hABC12, 20'h12345, 20'hFFF00);
        total_n++; if ({exp_req, exp_sel, exp_out, busy} !== {1'b1, 2'd0, 12'hABC, 1'b1}) $display("FAIL nom_req_a got %b/%h/%h/%b want 1/0/abc/1", exp_req, exp_sel, exp_out, busy); else pass_n++;
        tick;
        total_n++; if ({exp_req, exp_out} !== {1'b0, 12'hABC}) $display("FAIL nom_wait_a got %b/%h want 0/abc", exp_req, exp_out); else pass_n++;
        feed(16'h1111);
        total_n++; if ({valA, exp_req, exp_sel, exp_out} !== {16'h1111, 1'b1, 2'd1, 12'h123}) $display("FAIL nom_req_b got %h/%b/%h/%h want 1111/1/1/123", valA, exp_req, exp_sel, exp_out); else pass_n++;
        tick;
        feed(16'h2222);
        total_n++; if ({valB, exp_req, exp_sel, exp_out} !== {16'h2222, 1'b1, 2'd2, 12'hFFF}) $display("FAIL nom_req_c got %h/%b/%h/%h want 2222/1/2/fff", valB, exp_req, exp_sel, exp_out); else pass_n++;
        tick;
        feed(16'h3333);
        total_n++; if ({valC, solve_start, out_valid} !== {16'h3333, 1'b1, 1'b0}) $display("FAIL nom_solve got %h/%b/%b want 3333/1/0", valC, solve_start, out_valid); else pass_n++;
        tick;
        total_n++; if (solve_start !== 1'b0) $display("FAIL nom_wait_s got %b want 0", solve_start); else pass_n++;
        solve_done = 1'b1;
        tick;
        solve_done = 1'b0;
        // ninth rising edge counting the start edge: tenth cycle counting the start cycle
        total_n++; if ({out_valid, err, busy} !== 3'b101) $display("FAIL nom_done got %b%b%b want 101", out_valid, err, busy); else pass_n++;
        tick;
        total_n++; if ({out_valid, busy} !== 2'b00) $display("FAIL nom_idle got %b%b want 00", out_valid, busy); else pass_n++;
    endtask

    task automatic test_stall;
        launch(20'hABC12, 20'h12345, 20'hFFF00);
        tick;
        feed(16'h4444);
        tick;
        for (int i = 0; i < 6; i++) begin
            total_n++; if ({exp_req, exp_sel, exp_out, busy, out_valid} !== {1'b0, 2'd1, 12'h123, 1'b1, 1'b0}) $display("FAIL stall_b%0d got %b/%h/%h/%b/%b want 0/1/123/1/0", i, exp_req, exp_sel, exp_out, busy, out_valid); else pass_n++;
            tick;
        end
        feed(16'h5555);
        total_n++; if ({valA, valB} !== {16'h4444, 16'h5555}) $display("FAIL stall_vals got %h/%h want 4444/5555", valA, valB); else pass_n++;
        tick;
        feed(16'h6666);
        tick;
        for (int i = 0; i < 20; i++) begin
            total_n++; if ({busy, out_valid} !== 2'b10) $display("FAIL stall_s%0d got %b%b want 10", i, busy, out_valid); else pass_n++;
            tick;
        end
        solve_done = 1'b1;
        tick;
        solve_done = 1'b0;
        total_n++; if (out_valid !== 1'b1) $display("FAIL stall_done got %b want 1", out_valid); else pass_n++;
        tick;
        total_n++; if ({out_valid, busy} !== 2'b00) $display("FAIL stall_single got %b%b want 00", out_valid, busy); else pass_n++;
    endtask

    task automatic test_spurious;
        launch(20'h11100, 20'h22200, 20'h33300);
        tick;
        feed(16'h7777);
        tick;
        rssiA = 20'h99900; start = 1'b1;
        tick;
        start = 1'b0;
        total_n++; if ({exp_req, exp_sel, exp_out} !== {1'b0, 2'd1, 12'h222}) $display("FAIL spur_start got %b/%h/%h want 0/1/222", exp_req, exp_sel, exp_out); else pass_n++;
        feed(16'h8888);
        total_n++; if ({exp_sel, exp_out} !== {2'd2, 12'h333}) $display("FAIL spur_req_c got %h/%h want 2/333", exp_sel, exp_out); else pass_n++;
        tick;
        feed(16'h9999);
        tick;
        feed(16'hDEAD);
        total_n++; if ({valA, valB, valC} !== {16'h7777, 16'h8888, 16'h9999}) $display("FAIL spur_vld got %h/%h/%h want 7777/8888/9999", valA, valB, valC); else pass_n++;
        total_n++; if ({busy, out_valid} !== 2'b10) $display("FAIL spur_wait_s got %b%b want 10", busy, out_valid); else pass_n++;
        solve_done = 1'b1;
        tick;
        solve_done = 1'b0;
        total_n++; if (out_valid !== 1'b1) $display("FAIL spur_done got %b want 1", out_valid); else pass_n++;
        tick;
        feed(16'hBEEF);
        total_n++; if ({valA, busy} !== {16'h7777, 1'b0}) $display("FAIL spur_idle got %h/%b want 7777/0", valA, busy); else pass_n++;
    endtask

    task automatic test_reset_mid;
        launch(20'hABC12, 20'h12345, 20'hFFF00);
        tick;
        feed(16'h1111);
        tick;
        feed(16'h2222);
        tick;
        #2 rst = 1'b0;
        #1;
        total_n++; if ({busy, exp_req, out_valid, solve_start, err} !== 5'b0) $display("FAIL mid_ctl got %b%b%b%b%b want 00000", busy, exp_req, out_valid, solve_start, err); else pass_n++;
        total_n++; if ({exp_sel, exp_out, valA, valB, valC} !== 62'h0) $display("FAIL mid_data got %h/%h/%h/%h/%h want 0", exp_sel, exp_out, valA, valB, valC); else pass_n++;
        @(negedge clk);
        rst = 1'b1;
        launch(20'h45600, 20'h78900, 20'hABC00);
        total_n++; if ({exp_req, exp_sel, exp_out} !== {1'b1, 2'd0, 12'h456}) $display("FAIL mid_restart got %b/%h/%h want 1/0/456", exp_req, exp_sel, exp_out); else pass_n++;
        tick;
        feed(16'h0001);
        tick;
        feed(16'h0002);
        tick;
        feed(16'h0003);
        tick;
        solve_done = 1'b1;
        tick;
        solve_done = 1'b0;
        total_n++; if ({out_valid, valA, valB, valC} !== {1'b1, 16'h1, 16'h2, 16'h3}) $display("FAIL mid_rerun got %b/%h/%h/%h want 1/1/2/3", out_valid, valA, valB, valC); else pass_n++;
        tick;
    endtask

    task automatic test_timeout;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        launch(20'hABC12, 20'h12345, 20'hFFF00);
        tick;
`ifdef RFILE_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            total_n++; if ({busy, out_valid, solve_start} !== 3'b100) $display("FAIL tmo_wait%0d got %b%b%b want 100", i, busy, out_valid, solve_start); else pass_n++;
            tick;
        end
        tick;
        total_n++; if ({out_valid, err, solve_start, valA} !== {1'b1, 1'b1, 1'b0, 16'h0}) $display("FAIL tmo_done got %b/%b/%b/%h want 1/1/0/0000", out_valid, err, solve_start, valA); else pass_n++;
        tick;
        total_n++; if ({busy, err} !== 2'b00) $display("FAIL tmo_idle got %b%b want 00", busy, err); else pass_n++;
`else
        for (int i = 0; i < 30; i++) begin
            total_n++; if ({busy, out_valid, err} !== 3'b100) $display("FAIL notmo_wait%0d got %b%b%b want 100", i, busy, out_valid, err); else pass_n++;
            tick;
        end
        rst = 1'b0;
        tick;
        rst = 1'b1;
`endif
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_stall;
        test_spurious;
        test_reset_mid;
        test_timeout;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
